// File: rtl/bsg_fsb_pkg.sv
// Shared types for the FSB node level-shift power sequencer.
// The state encoding is fixed so the state register width is known to every user.
package bsg_fsb_pkg;

  localparam int unsigned bsg_fsb_ls_ctrl_state_width_lp = 3;

  typedef enum logic [bsg_fsb_ls_ctrl_state_width_lp-1:0] {
    OFF      = 3'd0,
    PWR_UP   = 3'd1,
    RST_HOLD = 3'd2,
    ON       = 3'd3,
    DRAIN    = 3'd4,
    ISOLATE  = 3'd5
  } bsg_fsb_ls_ctrl_state_e;

  function automatic int unsigned bsg_fsb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_fsb_ls_ctrl_quiet_cnt.sv
// Saturating counter with synchronous clear (clear wins over increment).
// Holds at max_p instead of wrapping.
module bsg_fsb_ls_ctrl_quiet_cnt
  import bsg_fsb_pkg::*;
#(
  parameter int unsigned max_p = 16,
  localparam int unsigned width_lp = $clog2(max_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                incr_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != width_lp'(max_p))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_fsb_node_ls_ctrl.sv
// Power/isolation sequencer for one switchable FSB node: orders power, level-shift
// enable and node reset, and drains in-flight traffic before clamping and powering down.
module bsg_fsb_node_ls_ctrl
  import bsg_fsb_pkg::*;
#(
  parameter int unsigned reset_cycles_p  = 16,
  parameter int unsigned quiet_cycles_p  = 4,
  parameter int unsigned drain_timeout_p = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pwr_on_req_i,
  input  logic pwr_good_i,
  input  logic fsb_v_o_i,
  input  logic node_v_o_i,
  output logic pwr_en_o,
  output logic en_ls_o,
  output logic node_reset_o,
  output logic block_o,
  output logic on_o,
  output logic timeout_o,
  output logic fault_o
);

  // One counter is shared between the reset hold and the quiet streak.
  localparam int unsigned hold_max_lp = bsg_fsb_max(reset_cycles_p, quiet_cycles_p);
  localparam int unsigned hold_w_lp   = $clog2(hold_max_lp + 1);
  localparam int unsigned tmo_w_lp    = $clog2(drain_timeout_p + 1);

  bsg_fsb_ls_ctrl_state_e state_d, state_q;
  logic timeout_d, timeout_q;
  logic fault_d, fault_q;

  logic                 hold_clear, hold_incr, hold_busy;
  logic                 tmo_clear, tmo_incr;
  logic [hold_w_lp-1:0] hold_cnt;
  logic [tmo_w_lp-1:0]  tmo_cnt;
  logic                 idle, quiet_done, tmo_done, rst_done;

  assign idle       = !fsb_v_o_i && !node_v_o_i;
  assign quiet_done = idle && (hold_cnt == hold_w_lp'(quiet_cycles_p - 1));
  assign tmo_done   = (tmo_cnt == tmo_w_lp'(drain_timeout_p - 1));
  assign rst_done   = (hold_cnt == hold_w_lp'(reset_cycles_p - 1));

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    fault_d   = fault_q;
    hold_incr = 1'b0;
    hold_busy = 1'b0;
    tmo_incr  = 1'b0;
    unique case (state_q)
      OFF: begin
        if (pwr_on_req_i) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (!pwr_on_req_i) state_d = OFF;
        else if (pwr_good_i) state_d = RST_HOLD;
      end
      RST_HOLD: begin
        if (!pwr_on_req_i || !pwr_good_i) state_d = ISOLATE;
        else if (rst_done) state_d = ON;
        else hold_incr = 1'b1;
      end
      ON: begin
        if (!pwr_good_i) begin
          state_d = ISOLATE;
          fault_d = 1'b1;
        end else if (!pwr_on_req_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A returning request is ignored here: once draining starts the node goes down.
        tmo_incr  = 1'b1;
        hold_incr = idle;
        hold_busy = !idle;
        if (!pwr_good_i) begin
          state_d = ISOLATE;
          fault_d = 1'b1;
        end else if (quiet_done) begin
          state_d = ISOLATE;
        end else if (tmo_done) begin
          state_d   = ISOLATE;
          timeout_d = 1'b1;
        end
      end
      ISOLATE: begin
        state_d = OFF;
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  assign hold_clear = (state_d != state_q) || hold_busy;
  assign tmo_clear  = (state_d != state_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= OFF;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
    end
  end

  bsg_fsb_ls_ctrl_quiet_cnt #(.max_p(hold_max_lp)) hold_cnt_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (hold_clear),
    .incr_i  (hold_incr),
    .count_o (hold_cnt)
  );

  bsg_fsb_ls_ctrl_quiet_cnt #(.max_p(drain_timeout_p)) tmo_cnt_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (tmo_clear),
    .incr_i  (tmo_incr),
    .count_o (tmo_cnt)
  );

  // Clamp is raised only while powered and lowered a full cycle before power goes.
  always_comb begin
    pwr_en_o     = (state_q != OFF);
    en_ls_o      = (state_q == RST_HOLD) || (state_q == ON) || (state_q == DRAIN);
    node_reset_o = !((state_q == ON) || (state_q == DRAIN));
    block_o      = (state_q != ON);
    on_o         = (state_q == ON);
    timeout_o    = timeout_q;
    fault_o      = fault_q;
  end

  a_ls_needs_pwr: assert property (@(posedge clk_i) disable iff (reset_i)
    en_ls_o |-> pwr_en_o);
  a_run_needs_ls: assert property (@(posedge clk_i) disable iff (reset_i)
    !node_reset_o |-> en_ls_o);
  a_no_joint_fall: assert property (@(posedge clk_i) disable iff (reset_i)
    (($past(reset_i) === 1'b0) && $fell(en_ls_o)) |-> !$fell(pwr_en_o));

endmodule

// File: tb/tb_bsg_fsb_node_ls_ctrl.sv
// Scoreboard bench for the node power sequencer: stimulus pushes expected outputs,
// a monitor pops and compares one entry per cycle and checks ordering invariants.
module tb_bsg_fsb_node_ls_ctrl;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic pwr_on_req_i = 1'b0;
  logic pwr_good_i = 1'b0;
  logic fsb_v_o_i = 1'b0;
  logic node_v_o_i = 1'b0;
  logic pwr_en_o, en_ls_o, node_reset_o, block_o, on_o, timeout_o, fault_o;

  // {pwr_en, en_ls, node_reset, block, on, timeout, fault}
  localparam logic [6:0] S_OFF = 7'b0011_0_00;
  localparam logic [6:0] S_PWR = 7'b1011_0_00;
  localparam logic [6:0] S_RST = 7'b1111_0_00;
  localparam logic [6:0] S_ON  = 7'b1100_1_00;
  localparam logic [6:0] S_DRN = 7'b1101_0_00;
  localparam logic [6:0] S_ISO = 7'b1011_0_00;
  localparam logic [6:0] F_TO  = 7'b0000_0_10;
  localparam logic [6:0] F_FLT = 7'b0000_0_01;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;
  logic prev_pwr, prev_en;

  always #5 clk_i = ~clk_i;

  bsg_fsb_node_ls_ctrl #(
    .reset_cycles_p  (16),
    .quiet_cycles_p  (4),
    .drain_timeout_p (256)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .pwr_on_req_i (pwr_on_req_i),
    .pwr_good_i   (pwr_good_i),
    .fsb_v_o_i    (fsb_v_o_i),
    .node_v_o_i   (node_v_o_i),
    .pwr_en_o     (pwr_en_o),
    .en_ls_o      (en_ls_o),
    .node_reset_o (node_reset_o),
    .block_o      (block_o),
    .on_o         (on_o),
    .timeout_o    (timeout_o),
    .fault_o      (fault_o)
  );

  task automatic applyStimulus(input logic rst, input logic req, input logic pg,
                               input logic fv, input logic nv,
                               input logic [6:0] exp, input string name);
    sb_entry_t e;
    @(negedge clk_i);
    reset_i      = rst;
    pwr_on_req_i = req;
    pwr_good_i   = pg;
    fsb_v_o_i    = fv;
    node_v_o_i   = nv;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input sb_entry_t e);
    logic [6:0] act;
    act = {pwr_en_o, en_ls_o, node_reset_o, block_o, on_o, timeout_o, fault_o};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s got %b exp %b", e.name, act, e.exp);
    end
  endtask

  task automatic powerUp(input logic [6:0] f);
    applyStimulus(0, 1, 1, 0, 0, S_PWR | f, "pwr_up");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 0, 0, S_RST | f, "rst_hold");
    applyStimulus(0, 1, 1, 0, 0, S_ON | f, "on");
  endtask

  // Monitor: one expected entry per clock, plus invariants once reset has been seen.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        sb_entry_t e;
        e = sb_q.pop_front();
        checkOutput(e);
        armed = 1'b1;
      end
      if (armed) begin
        checks++;
        if (en_ls_o && !pwr_en_o) begin
          errors++;
          $display("[TB] FAIL inv_ls_pwr en_ls=%b pwr_en=%b", en_ls_o, pwr_en_o);
        end
        checks++;
        if (!node_reset_o && !en_ls_o) begin
          errors++;
          $display("[TB] FAIL inv_rst_ls node_reset=%b en_ls=%b", node_reset_o, en_ls_o);
        end
        if (!reset_i) begin
          checks++;
          if (prev_pwr && !pwr_en_o && prev_en && !en_ls_o) begin
            errors++;
            $display("[TB] FAIL inv_joint_fall pwr_en %b->%b en_ls %b->%b",
                     prev_pwr, pwr_en_o, prev_en, en_ls_o);
          end
        end
      end
      prev_pwr = pwr_en_o;
      prev_en  = en_ls_o;
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, S_OFF, "reset0");
    applyStimulus(1, 0, 0, 0, 0, S_OFF, "reset1");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "off_idle0");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "off_idle1");
    powerUp('0);
    applyStimulus(0, 1, 1, 1, 1, S_ON, "on_hold");

    // Clean drain
    applyStimulus(0, 0, 1, 0, 0, S_DRN, "clean_drain_entry");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 0, 0, (i < 3) ? S_DRN : S_ISO, "clean_drain");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "clean_off");

    // Busy drain: forced isolation on timeout
    powerUp('0);
    applyStimulus(0, 0, 1, 0, 0, S_DRN, "busy_entry");
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 0, 1, 0, logic'(i % 3 == 0),
                    (i < 255) ? S_DRN : (S_ISO | F_TO), "busy_drain");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "busy_off");

    // Quiet streak completes on the same cycle the timeout expires: no pulse
    powerUp('0);
    applyStimulus(0, 0, 1, 0, 0, S_DRN, "tie_entry");
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 0, 1, 0, logic'((i <= 251) && ((i % 3 == 0) || (i == 251))),
                    (i < 255) ? S_DRN : S_ISO, "tie_drain");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "tie_off");

    // Broken quiet streak, request returns during drain, then PWR_UP abort
    powerUp('0);
    applyStimulus(0, 0, 1, 0, 0, S_DRN, "streak_entry");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 1, logic'(i == 3), 0, (i < 7) ? S_DRN : S_ISO, "streak_drain");
    applyStimulus(0, 1, 1, 0, 0, S_OFF, "rearm_off");
    applyStimulus(0, 1, 0, 0, 0, S_PWR, "rearm_pwr_up");
    applyStimulus(0, 0, 0, 0, 0, S_OFF, "abort_pwr_up");

    // Abort during reset hold
    applyStimulus(0, 1, 0, 0, 0, S_PWR, "hold_abort_pwr");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0, S_RST, "hold_abort_rst");
    applyStimulus(0, 0, 1, 0, 0, S_ISO, "hold_abort_iso");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "hold_abort_off");

    // Fault in ON is sticky through re-power
    powerUp('0);
    applyStimulus(0, 1, 0, 0, 0, S_ISO | F_FLT, "fault_iso");
    applyStimulus(0, 1, 0, 0, 0, S_OFF | F_FLT, "fault_off");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, S_PWR | F_FLT, "fault_pwr_wait");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, 0, 0, S_RST | F_FLT, "fault_rst_hold");
    applyStimulus(0, 1, 1, 0, 0, S_ON | F_FLT, "fault_on");

    // Reset in the middle of a drain
    applyStimulus(0, 0, 1, 0, 1, S_DRN | F_FLT, "rst_drain_entry");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1, S_DRN | F_FLT, "rst_drain");
    applyStimulus(1, 0, 1, 0, 1, S_OFF, "rst_in_drain");
    applyStimulus(0, 0, 1, 0, 0, S_OFF, "rst_after");

    // Fault during drain outranks everything else
    powerUp('0);
    applyStimulus(0, 0, 1, 0, 1, S_DRN, "dfault_entry");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 1, S_DRN, "dfault_drain");
    applyStimulus(0, 0, 0, 1, 1, S_ISO | F_FLT, "dfault_iso");
    applyStimulus(0, 0, 0, 0, 0, S_OFF | F_FLT, "dfault_off");
    applyStimulus(1, 0, 0, 0, 0, S_OFF, "final_reset");

    for (int k = 0; (k < 8) && (sb_q.size() > 0); k++) @(posedge clk_i);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
